clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel, run-time-programmable clock divider for the low-speed timing fabric. Each of NUM_CH channels produces a divided square wave and a one-cycle tick, all from a single system clock. Divisors can be reprogrammed while running and take effect glitch-free at the next half-period boundary. Channels can be individually frozen.

## Interface
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 32: counter and divisor width in bits.
- DEFAULT_DIV, 5000000: divisor loaded into every channel at reset; must fit in CNT_W.
- CH_W, $clog2(NUM_CH) (minimum 1): channel-select width (localparam).

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk externally.
- div_wr  in  1  divisor write strobe, one cycle per write.
- div_ch  in  CH_W  target channel for div_wr.
- div_val  in  CNT_W  new divisor value.
- enable  in  NUM_CH  per-channel run enable; low freezes the channel.
- sclk  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-clk pulse in the cycle each sclk bit changes, registered.
- pend  out  NUM_CH  high while a written divisor is waiting for its boundary.
- align  in  1  phase-align strobe; present only with CLKDIV_PHASE_ALIGN_EN.

## Operation
- Per-channel state: count[CNT_W], div_act[CNT_W], div_shadow[CNT_W], pend, sclk, tick.
- Half period = div_act+1 clk cycles; full period = 2*(div_act+1). A divisor of 0 gives sclk = clk/2.
- Enabled channel, count != div_act: count <= count+1; tick <= 0.
- Enabled channel, count == div_act (boundary): count <= 0; sclk toggles; tick <= 1. If pend is set, div_act <= div_shadow and pend <= 0.
- Disabled channel: count, sclk, div_act and pend hold; tick <= 0. Re-enabling resumes mid-half-period from the held count.
- div_wr with div_ch < NUM_CH: div_shadow[div_ch] <= div_val; pend <= 1. div_wr with div_ch >= NUM_CH is ignored.
- Back-to-back writes before a boundary: the last value wins; only one update is applied.
- A write in the same cycle as a boundary is captured in the shadow register. It applies at the following boundary, and pend stays 1.
- div_act never changes mid-half-period, so count cannot exceed div_act.
- Counter arithmetic is modulo 2^CNT_W. No other overflow is possible.

## Timing
- Reset values: count = 0, sclk = 0, tick = 0, pend = 0, div_act = div_shadow = DEFAULT_DIV.
- After reset release with enable high, the first sclk rise and tick occur at the (DEFAULT_DIV+1)th rising clk edge.
- tick is asserted in the same cycle that sclk shows its new value.
- pend rises the cycle after div_wr and falls in the cycle the new half-period starts.
- Reset asserted mid-operation: all outputs return to reset values immediately. Pending writes are discarded.
- Each enable bit is sampled every edge. Deasserting it on a boundary edge suppresses that toggle.

## Configuration
- CLKDIV_PHASE_ALIGN_EN defined: the align input port exists.
  - A one-cycle align forces every channel to count = 0, sclk = 0, tick = 0, regardless of enable.
  - Pending divisors are applied immediately and pend is cleared. All channels restart in phase.
  - align takes priority over div_wr in the same cycle; that write is lost.
- Macro undefined: no align port and no alignment logic. Channels are phase-related only through reset.

## Test plan
- NUM_CH=4, DEFAULT_DIV=3, enable=4'hF after reset -> every sclk toggles every 4 clks (period 8). First tick at edge 4. Channels are identical.
- Write div_val=1 to ch1 at count=1 -> the current half-period completes at 4 clks, then ch1 toggles every 2 clks. pend[1] is high for exactly the intervening cycles.
- Write div_val=0 to ch2 in the same cycle as its boundary -> one more 4-clk half-period, then sclk[2] toggles every clk. Write to div_ch=5 with NUM_CH=4 -> no change.
- enable[0] low for 10 clks at count=2 -> sclk[0] and count hold, tick[0] is 0. After re-enable the next toggle is 2 clks later.
- Reset pulsed low mid-half-period with a pending write -> sclk=0, tick=0, pend=0 asynchronously. After release, DEFAULT_DIV timing resumes.
- CLKDIV_PHASE_ALIGN_EN: channels at mixed phases and divisors, align pulse -> all sclk=0, count=0. Subsequent toggles land at div_act+1 clks per channel.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel run-time-programmable clock divider with glitch-free divisor updates.
// Optional phase-align strobe is built in when CLKDIV_PHASE_ALIGN_EN is defined.

module clock_divider_ch #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic             align,
`endif
    output logic             sclk,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
    logic             sclk_q, sclk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             boundary;

    always_comb begin
        boundary     = en && (count_q == div_act_q);
        count_d      = count_q;
        div_act_d    = div_act_q;
        div_shadow_d = div_shadow_q;
        sclk_d       = sclk_q;
        tick_d       = boundary;
        pend_d       = pend_q;

        if (en) count_d = boundary ? '0 : count_q + CNT_W'(1);
        if (boundary) begin
            sclk_d = ~sclk_q;
            // Shadow is consumed before a same-cycle write, which then re-arms pend.
            if (pend_q) begin
                div_act_d = div_shadow_q;
                pend_d    = 1'b0;
            end
        end
        if (wr) begin
            div_shadow_d = wr_val;
            pend_d       = 1'b1;
        end

`ifdef CLKDIV_PHASE_ALIGN_EN
        // Align overrides everything, including enable and a same-cycle write.
        if (align) begin
            count_d      = '0;
            sclk_d       = 1'b0;
            tick_d       = 1'b0;
            div_act_d    = pend_q ? div_shadow_q : div_act_q;
            div_shadow_d = div_shadow_q;
            pend_d       = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            div_act_q    <= DIV_RST;
            div_shadow_q <= DIV_RST;
            sclk_q       <= 1'b0;
            tick_q       <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            div_act_q    <= div_act_d;
            div_shadow_q <= div_shadow_d;
            sclk_q       <= sclk_d;
            tick_q       <= tick_d;
            pend_q       <= pend_d;
        end
    end

    assign sclk = sclk_q;
    assign tick = tick_q;
    assign pend = pend_q;

endmodule

module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 5000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    input  logic [NUM_CH-1:0] enable,
    output logic [NUM_CH-1:0] sclk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
`ifdef CLKDIV_PHASE_ALIGN_EN
    ,
    input  logic              align
`endif
);

    // One extra bit so NUM_CH itself is representable for the range check.
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic wr_ok;
    assign wr_ok = div_wr && ({1'b0, div_ch} < NUM_CH_L);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);
        clock_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (enable[i]),
            .wr     (wr_ok && (div_ch == IDX)),
            .wr_val (div_val),
`ifdef CLKDIV_PHASE_ALIGN_EN
            .align  (align),
`endif
            .sclk   (sclk[i]),
            .tick   (tick[i]),
            .pend   (pend[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomized bench for clock_divider_multi against a half-period countdown model.
// Three channels so that div_ch=3 exercises the out-of-range write path.

module tb_clock_divider_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DDIV   = 3;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              div_wr = 1'b0;
    logic [CH_W-1:0]   div_ch = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic [NUM_CH-1:0] enable = '0;
    logic [NUM_CH-1:0] sclk, tick, pend;
`ifdef CLKDIV_PHASE_ALIGN_EN
    logic              align = 1'b0;
`endif

    clock_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(reset), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .enable(enable), .sclk(sclk), .tick(tick), .pend(pend)
`ifdef CLKDIV_PHASE_ALIGN_EN
        , .align(align)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model: each channel counts down the edges left in its current half-period.
    int rem[NUM_CH];
    int hp[NUM_CH];
    int shd[NUM_CH];
    bit m_sclk[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_pend[NUM_CH];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            hp[c] = DDIV + 1; rem[c] = DDIV + 1; shd[c] = DDIV;
            m_sclk[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
        end
    endtask

    task automatic model_step(input bit al);
        for (int c = 0; c < NUM_CH; c++) begin
            if (al) begin
                if (m_pend[c]) hp[c] = shd[c] + 1;
                m_pend[c] = 0; m_sclk[c] = 0; m_tick[c] = 0; rem[c] = hp[c];
                continue;
            end
            m_tick[c] = 0;
            if (enable[c]) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    m_sclk[c] = !m_sclk[c];
                    m_tick[c] = 1;
                    if (m_pend[c]) begin
                        hp[c] = shd[c] + 1;
                        m_pend[c] = 0;
                    end
                    rem[c] = hp[c];
                end
            end
            if (div_wr && int'(div_ch) < NUM_CH && int'(div_ch) == c) begin
                shd[c] = int'(div_val);
                m_pend[c] = 1;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic [NUM_CH-1:0] es, et, ep;
        for (int c = 0; c < NUM_CH; c++) begin
            es[c] = m_sclk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
        end
        chk({pfx, "_sclk"}, 32'(sclk), 32'(es));
        chk({pfx, "_tick"}, 32'(tick), 32'(et));
        chk({pfx, "_pend"}, 32'(pend), 32'(ep));
    endtask

    task automatic run_cycles(input int n, input bit rand_in);
        bit al;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            al = 0;
`ifdef CLKDIV_PHASE_ALIGN_EN
            al = align;
`endif
            model_step(al);
            #1;
            check_outputs("run");
            if (rand_in) begin
                for (int c = 0; c < NUM_CH; c++) enable[c] = ($urandom_range(7) != 0);
                div_wr  = ($urandom_range(5) == 0);
                div_ch  = CH_W'($urandom_range(3));
                div_val = CNT_W'($urandom_range(6));
`ifdef CLKDIV_PHASE_ALIGN_EN
                align   = ($urandom_range(40) == 0);
`endif
            end
        end
    endtask

    initial begin
        // Reset state.
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset  = 1'b1;
        enable = '1;

        // Default timing: first toggle and tick on edge DDIV+1.
        run_cycles(12, 1'b0);

        // Directed: write to ch1 mid half-period, and an out-of-range write.
        div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd1;
        run_cycles(1, 1'b0);
        div_ch = 2'd3; div_val = 8'd0;
        run_cycles(1, 1'b0);
        div_wr = 1'b0;
        run_cycles(12, 1'b0);

        // Directed: freeze ch0 for 10 cycles.
        enable[0] = 1'b0;
        run_cycles(10, 1'b0);
        enable[0] = 1'b1;
        run_cycles(8, 1'b0);

        run_cycles(300, 1'b1);

        // Asynchronous reset mid-operation with a write pending.
        @(posedge clk);
        cyc++;
        model_step(1'b0);
        #1;
        check_outputs("pre_rst");
        div_wr = 1'b1; div_ch = 2'd2; div_val = 8'd5;
        @(posedge clk);
        cyc++;
        model_step(1'b0);
        #2;
        div_wr = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        reset  = 1'b1;
        enable = '1;
`ifdef CLKDIV_PHASE_ALIGN_EN
        align  = 1'b0;
`endif
        run_cycles(12, 1'b0);
        run_cycles(300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
